// File: rtl/dna_csr_axil.sv
// AXI4-Lite control/status register block for the DNA alignment array.
// Drives per-core start pulses and shared scoring config; gathers done/busy status.
module dna_csr_axil #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0200_4000,
    parameter int                    NUM_CORES   = 4,
    parameter int                    LEN_WIDTH   = 7,
    parameter int                    SCORE_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [NUM_CORES-1:0]      core_start_o,
    output logic [LEN_WIDTH-1:0]      core_len_o,
    output logic [SCORE_WIDTH-1:0]    match_o,
    output logic [SCORE_WIDTH-1:0]    mismatch_o,
    output logic [SCORE_WIDTH-1:0]    gap_o,
    input  logic [NUM_CORES-1:0]      core_busy_i,
    input  logic [NUM_CORES-1:0]      core_ref_empty_i,
    input  logic [NUM_CORES-1:0]      core_matrix_full_i,
    output logic                      irq_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_CONFIG = 3'd1;
    localparam logic [2:0] IDX_STATUS = 3'd2;
    localparam logic [2:0] IDX_DONE   = 3'd3;
    localparam logic [2:0] IDX_CYCLES = 3'd4;

    localparam logic [31:0] SCORE_MASK = (32'd1 << SCORE_WIDTH) - 32'd1;
    localparam logic [31:0] CFG_MASK   = ((32'd1 << LEN_WIDTH) - 32'd1)
                                       | (SCORE_MASK << 16)
                                       | (SCORE_MASK << 20)
                                       | (SCORE_MASK << 24);

    logic                  irq_en_q;
    logic [31:0]           cfg_q;
    logic [NUM_CORES-1:0]  start_q;
    logic [NUM_CORES-1:0]  done_q;
    logic [NUM_CORES-1:0]  busy_q;
    logic [31:0]           cycles_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rd_ready_q;

    logic                  wr_en;
    logic                  wr_ok;
    logic [2:0]            wr_idx;
    logic                  ar_en;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [31:0]           status;
    logic [NUM_CORES-1:0]  done_clr;
    logic [NUM_CORES-1:0]  busy_fell;

    // Misaligned addresses are treated as unmapped.
    assign wr_idx = s_awaddr[4:2];
    assign wr_ok  = (s_awaddr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5])
                  && (s_awaddr[1:0] == 2'b00) && (wr_idx <= IDX_CYCLES);

    assign wr_en     = s_awvalid & s_wvalid & ~bvalid_q;
    assign s_awready = wr_en;
    assign s_wready  = wr_en;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;

    // Held low for the first cycle after reset so every ready starts deasserted.
    assign s_arready = rd_ready_q & ~rvalid_q;
    assign ar_en     = s_arvalid & s_arready;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;

    assign core_start_o = start_q;
    assign core_len_o   = cfg_q[LEN_WIDTH-1:0];
    assign match_o      = cfg_q[16 +: SCORE_WIDTH];
    assign mismatch_o   = cfg_q[20 +: SCORE_WIDTH];
    assign gap_o        = cfg_q[24 +: SCORE_WIDTH];
    assign irq_o        = irq_en_q & (|done_q);

    assign busy_fell = busy_q & ~core_busy_i;
    assign done_clr  = (wr_en && wr_ok && wr_idx == IDX_DONE) ? s_wdata[NUM_CORES-1:0] : '0;

    always_comb begin
        status = '0;
        status[0  +: NUM_CORES] = core_busy_i;
        status[8  +: NUM_CORES] = core_ref_empty_i;
        status[16 +: NUM_CORES] = core_matrix_full_i;
    end

    always_comb begin
        rd_data = '0;
        rd_ok   = 1'b0;
        if ((s_araddr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]) && (s_araddr[1:0] == 2'b00)) begin
            rd_ok = 1'b1;
            case (s_araddr[4:2])
                IDX_CTRL:   rd_data[16] = irq_en_q;
                IDX_CONFIG: rd_data = cfg_q;
                IDX_STATUS: rd_data = status;
                IDX_DONE:   rd_data[NUM_CORES-1:0] = done_q;
                IDX_CYCLES: rd_data = cycles_q;
                default:    rd_ok = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            start_q  <= '0;
            irq_en_q <= 1'b0;
            cfg_q    <= '0;
        end else begin
            start_q <= '0;
            if (wr_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok && wr_idx == IDX_CTRL) begin
                    if (s_wstrb[0]) start_q  <= s_wdata[NUM_CORES-1:0];
                    if (s_wstrb[2]) irq_en_q <= s_wdata[16];
                end
                if (wr_ok && wr_idx == IDX_CONFIG) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_wstrb[b]) cfg_q[8*b +: 8] <= s_wdata[8*b +: 8] & CFG_MASK[8*b +: 8];
                    end
                end
            end else if (s_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // A done event in the same cycle as its W1C clear keeps the bit set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q   <= '0;
            done_q   <= '0;
            cycles_q <= '0;
        end else begin
            busy_q <= core_busy_i;
            done_q <= (done_q & ~done_clr) | busy_fell;
            if (|start_q) begin
                cycles_q <= '0;
            end else if ((|core_busy_i) && (cycles_q != 32'hFFFF_FFFF)) begin
                cycles_q <= cycles_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            rd_ready_q <= 1'b1;
            if (ar_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dna_csr_axil.sv
// Bench for dna_csr_axil: directed AXI-Lite traffic, expected responses queued
// by the stimulus and checked by an independent monitor.
module tb_dna_csr_axil;

    localparam logic [31:0] BASE = 32'h0200_4000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [3:0]  core_start_o;
    logic [6:0]  core_len_o;
    logic [2:0]  match_o;
    logic [2:0]  mismatch_o;
    logic [2:0]  gap_o;
    logic [3:0]  core_busy_i = '0;
    logic [3:0]  core_ref_empty_i = '0;
    logic [3:0]  core_matrix_full_i = '0;
    logic        irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    always #5 clk = ~clk;

    dna_csr_axil dut (
        .clk(clk), .resetn(resetn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .core_start_o(core_start_o), .core_len_o(core_len_o),
        .match_o(match_o), .mismatch_o(mismatch_o), .gap_o(gap_o),
        .core_busy_i(core_busy_i), .core_ref_empty_i(core_ref_empty_i),
        .core_matrix_full_i(core_matrix_full_i), .irq_o(irq_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    always @(negedge clk) begin
        if (resetn && s_bvalid && s_bready) begin
            if (bq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL bresp_unexpected: got 0x%0h, expected no response", s_bresp);
            end else begin
                check("bresp", {30'd0, s_bresp}, {30'd0, bq.pop_front()});
            end
        end
        if (resetn && s_rvalid && s_rready) begin
            if (rq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rdata_unexpected: got 0x%08h, expected no response", s_rdata);
            end else begin
                logic [33:0] e;
                e = rq.pop_front();
                check("rresp", {30'd0, s_rresp}, {30'd0, e[33:32]});
                check("rdata", s_rdata, e[31:0]);
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, output logic [3:0] start_seen);
        int cnt;
        start_seen = '0;
        bq.push_back(exp_resp);
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        cnt = 0;
        while (!s_awready && cnt < 50) begin @(negedge clk); cnt++; end
        if (!s_awready) begin timeout_fail("aw_accept"); s_awvalid = 1'b0; s_wvalid = 1'b0; return; end
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clk);
        start_seen = core_start_o;
        cnt = 0;
        while (!s_bvalid && cnt < 50) begin @(negedge clk); cnt++; end
        if (!s_bvalid) timeout_fail("bvalid");
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int cnt;
        rq.push_back({exp_resp, exp_data});
        s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
        cnt = 0;
        while (!s_arready && cnt < 50) begin @(negedge clk); cnt++; end
        if (!s_arready) begin timeout_fail("ar_accept"); s_arvalid = 1'b0; return; end
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        cnt = 0;
        while (!s_rvalid && cnt < 50) begin @(negedge clk); cnt++; end
        if (!s_rvalid) timeout_fail("rvalid");
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ss;
        int cnt;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bvalid", {31'd0, s_bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, s_rvalid}, 32'd0);
        check("rst_arready", {31'd0, s_arready}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_start", {28'd0, core_start_o}, 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;

        // CONFIG full-word write and readback
        axi_write(BASE + 32'h04, 32'h0534_0040, 4'hF, 2'b00, ss);
        check("cfg_len", {25'd0, core_len_o}, 32'h40);
        check("cfg_match", {29'd0, match_o}, 32'd4);
        check("cfg_mismatch", {29'd0, mismatch_o}, 32'd3);
        check("cfg_gap", {29'd0, gap_o}, 32'd5);
        axi_read(BASE + 32'h04, 32'h0534_0040, 2'b00);

        // Byte strobe: only byte 0 changes, masked to 7 bits
        axi_write(BASE + 32'h04, 32'hFFFF_FFFF, 4'b0001, 2'b00, ss);
        check("cfg_strb_len", {25'd0, core_len_o}, 32'h7F);
        axi_read(BASE + 32'h04, 32'h0534_007F, 2'b00);

        // Start pulse on cores 0 and 2, irq_en set
        axi_write(BASE + 32'h00, 32'h0001_0005, 4'hF, 2'b00, ss);
        check("start_pulse", {28'd0, ss}, 32'h5);
        check("start_cleared", {28'd0, core_start_o}, 32'h0);
        axi_read(BASE + 32'h00, 32'h0001_0000, 2'b00);
        check("irq_idle", {31'd0, irq_o}, 32'd0);

        // Strobe clear on byte 0 and 2: no pulse, irq_en kept
        axi_write(BASE + 32'h00, 32'h0000_000F, 4'b1010, 2'b00, ss);
        check("start_strb_off", {28'd0, ss}, 32'h0);
        axi_read(BASE + 32'h00, 32'h0001_0000, 2'b00);

        // Busy for 10 cycles, then done and irq
        axi_read(BASE + 32'h10, 32'd0, 2'b00);
        core_busy_i = 4'b0001;
        repeat (10) @(posedge clk);
        #1 core_busy_i = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check("irq_done", {31'd0, irq_o}, 32'd1);
        axi_read(BASE + 32'h0C, 32'd1, 2'b00);
        axi_read(BASE + 32'h10, 32'd10, 2'b00);
        axi_write(BASE + 32'h0C, 32'd1, 4'hF, 2'b00, ss);
        check("irq_cleared", {31'd0, irq_o}, 32'd0);
        axi_read(BASE + 32'h0C, 32'd0, 2'b00);

        // W1C landing on the falling-edge cycle: set wins
        core_busy_i = 4'b0001;
        repeat (3) @(posedge clk);
        #1 core_busy_i = 4'b0000;
        axi_write(BASE + 32'h0C, 32'd1, 4'hF, 2'b00, ss);
        axi_read(BASE + 32'h0C, 32'd1, 2'b00);
        check("irq_collide", {31'd0, irq_o}, 32'd1);
        axi_write(BASE + 32'h0C, 32'd1, 4'hF, 2'b00, ss);
        axi_read(BASE + 32'h0C, 32'd0, 2'b00);

        // Unmapped and out-of-window accesses
        axi_write(BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF, 2'b10, ss);
        axi_write(BASE + 32'h404, 32'h0000_0000, 4'hF, 2'b10, ss);
        axi_read(32'h2000_0000, 32'd0, 2'b10);
        axi_read(BASE + 32'h1C, 32'd0, 2'b10);
        axi_read(BASE + 32'h04, 32'h0534_007F, 2'b00);

        // Back-pressure on B with a second write pending
        bq.push_back(2'b00);
        bq.push_back(2'b00);
        s_awaddr = BASE + 32'h04; s_wdata = 32'h0111_0011; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        @(posedge clk); #1;
        s_wdata = 32'h0222_0022;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_awready", {31'd0, s_awready}, 32'd0);
        end
        check("hold_len", {25'd0, core_len_o}, 32'h11);
        @(posedge clk); #1 s_bready = 1'b1;
        cnt = 0;
        while (!s_awready && cnt < 50) begin @(negedge clk); cnt++; end
        if (!s_awready) timeout_fail("hold_second_accept");
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        cnt = 0;
        while (!s_bvalid && cnt < 50) begin @(negedge clk); cnt++; end
        if (!s_bvalid) timeout_fail("hold_second_bvalid");
        @(posedge clk); #1;
        check("hold_len2", {25'd0, core_len_o}, 32'h22);
        axi_read(BASE + 32'h04, 32'h0222_0022, 2'b00);

        // Live status
        core_busy_i = 4'b0010; core_ref_empty_i = 4'b1000; core_matrix_full_i = 4'b0001;
        @(posedge clk); #1;
        axi_read(BASE + 32'h08, 32'h0001_0802, 2'b00);

        // Reset during a pending write response
        bq.push_back(2'b00);
        s_awaddr = BASE + 32'h04; s_wdata = 32'h0333_0033; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        core_busy_i = '0; core_ref_empty_i = '0; core_matrix_full_i = '0;
        @(negedge clk);
        check("mid_rst_bvalid", {31'd0, s_bvalid}, 32'd0);
        check("mid_rst_len", {25'd0, core_len_o}, 32'd0);
        check("mid_rst_scores", {23'd0, match_o, mismatch_o, gap_o}, 32'd0);
        check("mid_rst_irq", {31'd0, irq_o}, 32'd0);
        bq.delete();
        @(posedge clk); #1 resetn = 1'b1;
        axi_read(BASE + 32'h04, 32'd0, 2'b00);
        axi_read(BASE + 32'h00, 32'd0, 2'b00);

        repeat (3) @(posedge clk);
        check("bq_drained", bq.size(), 32'd0);
        check("rq_drained", rq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dna_csr_axil.md
# dna_csr_axil

Multi-core AXI4-Lite control/status register block for the DNA alignment array. It has its own AXI4-Lite slave handshake and decodes a parametrised base address. It drives self-clearing per-core start pulses and shared scoring configuration, and collects per-core status into sticky done bits, a busy-cycle counter and a level interrupt. It sits between the SoC interconnect and `NUM_CORES` instances of the DNA core.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: AXI data width; fixed at 32.
- `BASE_ADDR`, 32'h0200_4000: register window base; window is 32 bytes.
- `NUM_CORES`, 4: core count, 1..8.
- `LEN_WIDTH`, 7: read-length field width, ≤16.
- `SCORE_WIDTH`, 3: match/mismatch/gap field width, ≤4.

Ports, clock and reset first. Reset is `resetn`, asynchronous, active-low; clock is `clk`.
- `clk` in 1: clock.
- `resetn` in 1: asynchronous active-low reset.
- `s_awaddr` in ADDR_WIDTH, `s_awvalid` in 1, `s_awready` out 1: write address channel.
- `s_wdata` in 32, `s_wstrb` in 4, `s_wvalid` in 1, `s_wready` out 1: write data channel.
- `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1: write response channel.
- `s_araddr` in ADDR_WIDTH, `s_arvalid` in 1, `s_arready` out 1: read address channel.
- `s_rdata` out 32, `s_rresp` out 2, `s_rvalid` out 1, `s_rready` in 1: read data channel.
- `core_start_o` out NUM_CORES: one-cycle start pulse per core.
- `core_len_o` out LEN_WIDTH: read length, shared by all cores.
- `match_o`, `mismatch_o`, `gap_o` out SCORE_WIDTH each: scoring values, shared by all cores.
- `core_busy_i` in NUM_CORES: per-core en/busy.
- `core_ref_empty_i` in NUM_CORES: per-core reference-empty flag.
- `core_matrix_full_i` in NUM_CORES: per-core matrix-full flag.
- `irq_o` out 1: interrupt, level-sensitive.

## Operation
Register map (offsets from `BASE_ADDR`):
- 0x00 CTRL.
  - Writing 1 to bit [i] (i < NUM_CORES) produces a start pulse for core i.
  - Bit 16 is `irq_en` and is read/write.
  - Start bits read back 0.
- 0x04 CONFIG, read/write.
  - Length in [15:0], truncated to LEN_WIDTH.
  - Match in [19:16], mismatch in [23:20], gap in [27:24]; each uses its low SCORE_WIDTH bits.
  - Readback is zero-extended.
- 0x08 STATUS, read-only, live inputs: busy in [NUM_CORES-1:0], ref_empty at [8+i], matrix_full at [16+i].
- 0x0C DONE, write-1-to-clear. Bit i is set when `core_busy_i[i]` falls, detected against a one-cycle registered copy of `core_busy_i`.
- 0x10 CYCLES, read-only, 32-bit.
  - Cleared on any start pulse.
  - Increments each cycle while |core_busy_i.
  - Saturates at 32'hFFFF_FFFF.
- Unmapped offsets within the window and addresses outside the window:
  - Writes are ignored and return `bresp`=2'b10 (SLVERR).
  - Reads return `rdata`=0 and `rresp`=2'b10.
- `wstrb` is honoured per byte on CTRL and CONFIG. A byte with its strobe clear is unchanged and generates no start pulse.
- `irq_o` = irq_en & |DONE.

## Timing
- Reset values: every output and register is 0, so all AXI ready/valid signals are low and `irq_o`=0. Reset asserted mid-transaction drops any pending `bvalid`/`rvalid`.
- Write handshake:
  - `s_awready` = `s_wready` = `s_awvalid & s_wvalid & ~s_bvalid` (combinational). Address and data are always accepted in the same cycle T.
  - Register update, `core_start_o` pulse (exactly one cycle) and `s_bvalid` all occur at T+1.
  - `s_bvalid` holds until `s_bready`. No new write is accepted while `s_bvalid` is high.
- Read handshake:
  - `s_arready` = `~s_rvalid`.
  - Accept at T gives `s_rvalid` and a registered `s_rdata` at T+1, sampling state as of T.
  - `rdata` and `rresp` are held stable until `s_rready`. One read is outstanding at most.
- Reads and writes are independent and may complete in the same cycle.
- Simultaneous events:
  - Done set and W1C clear of the same bit in the same cycle: set wins.
  - Start pulse and counter increment in the same cycle: counter becomes 0.
  - Start issued to a core already busy: pulse is still emitted; the core ignores it.
- Done latency: `core_busy_i` falls at cycle T; DONE bit and `irq_o` are high at T+1.

## Test plan
- Reset with `resetn`=0 mid-write → `s_bvalid`=0, all config outputs 0, `irq_o`=0; subsequent read of 0x04 → 0.
- Write 0x04 = 32'h0534_0040 with wstrb 4'hF → `core_len_o`=7'h40, `match_o`=4'h4 & mask, `mismatch_o`=3, `gap_o`=5; readback matches masked values.
- Write 0x00 = 32'h0001_0005 → `core_start_o`=4'b0101 for exactly one cycle; CTRL readback = 32'h0001_0000.
- Drive `core_busy_i[0]` high for 10 cycles then low → CYCLES reads 10, DONE=1, `irq_o`=1; write 0x0C=1 → DONE=0, `irq_o`=0. Repeat with the clear landing on the falling-edge cycle → DONE stays 1.
- Write to offset 0x1C and read 0x2000_0000 → SLVERR on both, rdata 0, no state change.
- Hold `s_bready`=0 for 5 cycles with a second write pending → `s_awready` stays 0 until the response is taken; no write is lost or duplicated.
